stopwatch_ctrl: RTL and testbench

//   Stopwatch control and timebase stage, directly downstream of the push-button debouncers.

---
 rtl/stopwatch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timebase: 4-state FSM fed by debounced press pulses,
// 10 ms prescaler and a BCD MM:SS.cc counter with lap freeze and sticky overflow.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic        CLK,
    input  logic        XRST,
    input  logic        START_P,
    input  logic        LAP_P,
    output logic [23:0] DISP_BCD,
    output logic        RUNNING,
    output logic        LAP_ACT,
    output logic        OVF,
    output logic        TICK
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam logic [19:0] TICK_LAST  = 20'(TICK_DIV - 32'd1);
    localparam logic [23:0] COUNT_LAST = 24'h595999;

    // Increment a {min10,min1,sec10,sec1,cs10,cs1} BCD value; digits rippling
    // only when every lower digit sits at its maximum, so codes stay legal.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  dmax;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmax = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] >= dmax) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] presc_r;
    logic [19:0] presc_nxt_s;
    logic [23:0] count_r;
    logic [23:0] count_nxt_s;
    logic [23:0] lap_latch_r;
    logic [23:0] lap_latch_nxt_s;
    logic        ovf_r;
    logic        ovf_nxt_s;
    logic        tick_r;
    logic        running_r;
    logic        lap_act_r;
    logic        lap_load_s;
    logic        clear_s;
    logic        counting_s;
    logic        tick_hit_s;

    // Next-state decode; START_P always takes priority over LAP_P.
    always_comb begin
        state_nxt_s = state_r;
        lap_load_s  = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START_P) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (START_P) begin
                    state_nxt_s = ST_STOP;
                end else if (LAP_P) begin
                    state_nxt_s = ST_LAP;
                    lap_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (START_P) begin
                    state_nxt_s = ST_STOP;
                end else if (LAP_P) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_STOP: begin
                if (START_P) begin
                    state_nxt_s = ST_RUN;
                end else if (LAP_P) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Timebase and counter datapath; the prescaler only advances while counting.
    always_comb begin
        counting_s      = (state_r == ST_RUN) || (state_r == ST_LAP);
        tick_hit_s      = counting_s && (presc_r == TICK_LAST);
        presc_nxt_s     = presc_r;
        count_nxt_s     = count_r;
        ovf_nxt_s       = ovf_r;
        lap_latch_nxt_s = lap_latch_r;
        if (clear_s) begin
            presc_nxt_s = 20'd0;
            count_nxt_s = 24'd0;
            ovf_nxt_s   = 1'b0;
        end else if (tick_hit_s) begin
            presc_nxt_s = 20'd0;
            count_nxt_s = bcd_inc(count_r);
            if (count_r == COUNT_LAST) begin
                ovf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end else if (counting_s) begin
            presc_nxt_s = presc_r + 20'd1;
        end else begin
            presc_nxt_s = presc_r;
        end
        if (lap_load_s) begin
            lap_latch_nxt_s = count_r;
        end else begin
            lap_latch_nxt_s = lap_latch_r;
        end
    end

    // State and datapath registers; status flags registered alongside the state.
    always_ff @(posedge CLK) begin
        if (XRST) begin
            state_r     <= ST_IDLE;
            presc_r     <= 20'd0;
            count_r     <= 24'd0;
            lap_latch_r <= 24'd0;
            ovf_r       <= 1'b0;
            tick_r      <= 1'b0;
            running_r   <= 1'b0;
            lap_act_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            presc_r     <= presc_nxt_s;
            count_r     <= count_nxt_s;
            lap_latch_r <= lap_latch_nxt_s;
            ovf_r       <= ovf_nxt_s;
            tick_r      <= tick_hit_s;
            running_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
            lap_act_r   <= (state_nxt_s == ST_LAP);
        end
    end

    assign DISP_BCD = lap_act_r ? lap_latch_r : count_r;
    assign RUNNING  = running_r;
    assign LAP_ACT  = lap_act_r;
    assign OVF      = ovf_r;
    assign TICK     = tick_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle tick.
module tb_stopwatch_ctrl;

    logic        CLK;
    logic        XRST;
    logic        START_P;
    logic        LAP_P;
    logic [23:0] DISP_BCD;
    logic        RUNNING;
    logic        LAP_ACT;
    logic        OVF;
    logic        TICK;

    int total;
    int bad;

    typedef struct {
        logic        start;
        logic        lap;
        logic [27:0] exp;   // {disp, running, lap_act, ovf, tick}
    } vec_t;

    vec_t vecs[19];

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .CLK      (CLK),
        .XRST     (XRST),
        .START_P  (START_P),
        .LAP_P    (LAP_P),
        .DISP_BCD (DISP_BCD),
        .RUNNING  (RUNNING),
        .LAP_ACT  (LAP_ACT),
        .OVF      (OVF),
        .TICK     (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [27:0] outs();
        return {DISP_BCD, RUNNING, LAP_ACT, OVF, TICK};
    endfunction

    task automatic chk(input string nm, input logic [27:0] got, input logic [27:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        XRST = 1'b1;
        step(1);
        XRST = 1'b0;
    endtask

    task automatic press(input logic s, input logic l);
        START_P = s;
        LAP_P   = l;
        step(1);
        START_P = 1'b0;
        LAP_P   = 1'b0;
    endtask

    // Park the stopped count just below the wrap point, then resume.
    task automatic preload_near_wrap();
        press(1'b1, 1'b0);          // IDLE -> RUN, prescaler 0
        press(1'b1, 1'b0);          // RUN -> STOP, prescaler 1
        force dut.count_r = 24'h595998;
        step(1);
        release dut.count_r;
        step(1);
        chk("preload", {4'd0, DISP_BCD}, {4'd0, 24'h595998});
        press(1'b1, 1'b0);          // STOP -> RUN, prescaler held at 1
    endtask

    initial begin
        int  ticks;
        logic ok;
        total   = 0;
        bad     = 0;
        XRST    = 1'b0;
        START_P = 1'b0;
        LAP_P   = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, {24'h000000, 4'b1000}};
        vecs[1]  = '{1'b0, 1'b0, {24'h000000, 4'b1000}};
        vecs[2]  = '{1'b0, 1'b0, {24'h000000, 4'b1000}};
        vecs[3]  = '{1'b0, 1'b0, {24'h000000, 4'b1000}};
        vecs[4]  = '{1'b0, 1'b0, {24'h000001, 4'b1001}};
        vecs[5]  = '{1'b0, 1'b1, {24'h000001, 4'b1100}};
        vecs[6]  = '{1'b0, 1'b0, {24'h000001, 4'b1100}};
        vecs[7]  = '{1'b0, 1'b0, {24'h000001, 4'b1100}};
        vecs[8]  = '{1'b0, 1'b0, {24'h000001, 4'b1101}};
        vecs[9]  = '{1'b1, 1'b1, {24'h000002, 4'b0000}};
        vecs[10] = '{1'b0, 1'b0, {24'h000002, 4'b0000}};
        vecs[11] = '{1'b1, 1'b0, {24'h000002, 4'b1000}};
        vecs[12] = '{1'b0, 1'b0, {24'h000002, 4'b1000}};
        vecs[13] = '{1'b0, 1'b0, {24'h000002, 4'b1000}};
        vecs[14] = '{1'b0, 1'b0, {24'h000003, 4'b1001}};
        vecs[15] = '{1'b1, 1'b0, {24'h000003, 4'b0000}};
        vecs[16] = '{1'b0, 1'b1, {24'h000000, 4'b0000}};
        vecs[17] = '{1'b0, 1'b1, {24'h000000, 4'b0000}};
        vecs[18] = '{1'b1, 1'b1, {24'h000000, 4'b1000}};

        step(2);
        do_reset();
        chk("reset_state", outs(), 28'd0);

        // Cycle-by-cycle table.
        for (int i = 0; i < 19; i++) begin
            START_P = vecs[i].start;
            LAP_P   = vecs[i].lap;
            step(1);
            START_P = 1'b0;
            LAP_P   = 1'b0;
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Basic run: 400 cycles -> 00:01.00, 100 ticks.
        do_reset();
        press(1'b1, 1'b0);
        chk("run_running", {27'd0, RUNNING}, 28'd1);
        ticks = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (TICK) ticks++;
        end
        chk("run_disp", {4'd0, DISP_BCD}, {4'd0, 24'h000100});
        chk("run_ticks", 28'(ticks), 28'd100);

        // Stop / hold / resume / clear.
        do_reset();
        press(1'b1, 1'b0);
        step(92);
        press(1'b1, 1'b0);
        chk("stop_disp", {4'd0, DISP_BCD}, {4'd0, 24'h000023});
        step(200);
        chk("stop_hold", outs(), {24'h000023, 4'b0000});
        press(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!ok) begin
                step(1);
                if (DISP_BCD == 24'h000024) ok = 1'b1;
            end
        end
        chk("resume_24", {27'd0, ok}, 28'd1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("clear", outs(), 28'd0);

        // Lap freeze.
        do_reset();
        press(1'b1, 1'b0);
        step(40);
        chk("lap_pre", {4'd0, DISP_BCD}, {4'd0, 24'h000010});
        press(1'b0, 1'b1);
        chk("lap_enter", outs(), {24'h000010, 4'b1100});
        ok    = 1'b1;
        ticks = 0;
        for (int i = 0; i < 120; i++) begin
            step(1);
            if (TICK) ticks++;
            if (DISP_BCD != 24'h000010) ok = 1'b0;
        end
        chk("lap_frozen", {27'd0, ok}, 28'd1);
        chk("lap_ticks", 28'(ticks), 28'd30);
        press(1'b0, 1'b1);
        chk("lap_exit", outs(), {24'h000040, 4'b1000});

        // Wrap, sticky OVF, clear via STOP + LAP_P.
        do_reset();
        preload_near_wrap();
        step(3);
        chk("wrap_max", outs(), {24'h595999, 4'b1001});
        step(4);
        chk("wrap_zero", outs(), {24'h000000, 4'b1011});
        press(1'b1, 1'b0);
        chk("ovf_sticky", {27'd0, OVF}, 28'd1);
        press(1'b0, 1'b1);
        chk("ovf_clear", outs(), 28'd0);

        // Reset mid-run with OVF set discards everything.
        preload_near_wrap();
        step(9);
        chk("ovf_again", {26'd0, RUNNING, OVF}, 28'd3);
        do_reset();
        chk("reset_midrun", outs(), 28'd0);

        // Simultaneous presses in RUN: start wins.
        press(1'b1, 1'b0);
        step(10);
        press(1'b1, 1'b1);
        chk("prio_stop", {26'd0, RUNNING, LAP_ACT}, 28'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
